// File: rtl/fairy_mem_arbiter_if.sv
// fairy_mem_arbiter_if
//   Unified memory port that the arbiter drives toward the SRAM controller.
//   master : arbiter side (drives request fields, receives ack/rrdy/rdata)
//   slave  : memory side
// Signals:
//   mem_cen   [3:0]  active-low byte enables, 4'b1111 = no request
//   mem_wr           write strobe
//   mem_addr  [31:0] word address
//   mem_wdata [31:0] write data
//   mem_ack          memory accepted the request this cycle
//   mem_rrdy         read data valid this cycle
//   mem_rdata [31:0] read data
interface fairy_mem_arbiter_if;
  logic [3:0]  mem_cen;
  logic        mem_wr;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_ack;
  logic        mem_rrdy;
  logic [31:0] mem_rdata;

  modport master (
    output mem_cen, mem_wr, mem_addr, mem_wdata,
    input  mem_ack, mem_rrdy, mem_rdata
  );

  modport slave (
    input  mem_cen, mem_wr, mem_addr, mem_wdata,
    output mem_ack, mem_rrdy, mem_rdata
  );
endinterface

// File: rtl/fairy_mem_arbiter.sv
// fairy_mem_arbiter
//   Merges the core's instruction-fetch and data ports onto one handshaked
//   memory port. One transaction at a time, data has priority over fetch,
//   and a watchdog forces an error completion if the memory stalls.
// Ports:
//   aclk, areset_n         clock, asynchronous active-low reset
//   i_req/i_addr           fetch request (held until i_done)
//   i_done/i_rdata         fetch completion pulse and registered data
//   d_req/d_wr/d_cen/      data request: store/load, active-low byte
//   d_addr/d_wdata         enables, address, store data
//   d_done/d_rdata         data completion pulse and registered load data
//   err                    pulses with the done pulse on a timeout
//   bus                    unified memory port (master modport)
module fairy_mem_arbiter #(
  parameter int          TIMEOUT  = 255,
  parameter int          TO_W     = 8,
  parameter logic [31:0] ERR_DATA = 32'h0000_0000
) (
  input  logic        aclk,
  input  logic        areset_n,
  input  logic        i_req,
  input  logic [31:0] i_addr,
  output logic        i_done,
  output logic [31:0] i_rdata,
  input  logic        d_req,
  input  logic        d_wr,
  input  logic [3:0]  d_cen,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic        d_done,
  output logic [31:0] d_rdata,
  output logic        err,
  fairy_mem_arbiter_if.master bus
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT_RD, DONE} state_t;
  typedef enum logic {OWN_INST, OWN_DATA} owner_t;

  // Watchdog trips on the cycle it would otherwise count to TIMEOUT.
  localparam logic [TO_W-1:0] WD_LAST = TO_W'(TIMEOUT - 1);

  state_t      state_reg, state_next;
  owner_t      owner_reg, owner_next;
  logic [TO_W-1:0] wd_reg, wd_next;
  logic [3:0]  cen_reg, cen_next;
  logic        wr_reg, wr_next;
  logic [31:0] addr_reg, addr_next;
  logic [31:0] wdata_reg, wdata_next;
  logic        i_done_reg, i_done_next;
  logic        d_done_reg, d_done_next;
  logic        err_reg, err_next;
  logic [31:0] i_rdata_reg, i_rdata_next;
  logic [31:0] d_rdata_reg, d_rdata_next;

  always_ff @(posedge aclk or negedge areset_n) begin
    if (!areset_n) begin
      state_reg   <= IDLE;
      owner_reg   <= OWN_INST;
      wd_reg      <= '0;
      cen_reg     <= 4'hF;
      wr_reg      <= 1'b0;
      addr_reg    <= '0;
      wdata_reg   <= '0;
      i_done_reg  <= 1'b0;
      d_done_reg  <= 1'b0;
      err_reg     <= 1'b0;
      i_rdata_reg <= '0;
      d_rdata_reg <= '0;
    end else begin
      state_reg   <= state_next;
      owner_reg   <= owner_next;
      wd_reg      <= wd_next;
      cen_reg     <= cen_next;
      wr_reg      <= wr_next;
      addr_reg    <= addr_next;
      wdata_reg   <= wdata_next;
      i_done_reg  <= i_done_next;
      d_done_reg  <= d_done_next;
      err_reg     <= err_next;
      i_rdata_reg <= i_rdata_next;
      d_rdata_reg <= d_rdata_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    owner_next   = owner_reg;
    wd_next      = wd_reg;
    cen_next     = cen_reg;
    wr_next      = wr_reg;
    addr_next    = addr_reg;
    wdata_next   = wdata_reg;
    i_done_next  = 1'b0;
    d_done_next  = 1'b0;
    err_next     = 1'b0;
    i_rdata_next = i_rdata_reg;
    d_rdata_next = d_rdata_reg;

    unique case (state_reg)
      IDLE: begin
        if (d_req) begin
          cen_next   = d_cen;
          wr_next    = d_wr;
          addr_next  = d_addr;
          wdata_next = d_wdata;
          owner_next = OWN_DATA;
          wd_next    = '0;
          state_next = REQ;
        end else if (i_req) begin
          cen_next   = 4'h0;
          wr_next    = 1'b0;
          addr_next  = i_addr;
          owner_next = OWN_INST;
          wd_next    = '0;
          state_next = REQ;
        end
      end

      REQ: begin
        // mem_rrdy is deliberately not looked at here; read data is only
        // accepted once the request phase has been acknowledged.
        if (bus.mem_ack) begin
          cen_next = 4'hF;
          wr_next  = 1'b0;
          if (wr_reg) begin
            d_done_next = 1'b1;
            state_next  = DONE;
          end else begin
            wd_next    = '0;
            state_next = WAIT_RD;
          end
        end else if (wd_reg == WD_LAST) begin
          cen_next    = 4'hF;
          wr_next     = 1'b0;
          err_next    = 1'b1;
          i_done_next = (owner_reg == OWN_INST);
          d_done_next = (owner_reg == OWN_DATA);
          if (!wr_reg) begin
            if (owner_reg == OWN_INST) i_rdata_next = ERR_DATA;
            else                       d_rdata_next = ERR_DATA;
          end
          state_next = DONE;
        end else begin
          wd_next = wd_reg + 1'b1;
        end
      end

      WAIT_RD: begin
        if (bus.mem_rrdy || (wd_reg == WD_LAST)) begin
          err_next    = !bus.mem_rrdy;
          i_done_next = (owner_reg == OWN_INST);
          d_done_next = (owner_reg == OWN_DATA);
          if (owner_reg == OWN_INST)
            i_rdata_next = bus.mem_rrdy ? bus.mem_rdata : ERR_DATA;
          else
            d_rdata_next = bus.mem_rrdy ? bus.mem_rdata : ERR_DATA;
          state_next = DONE;
        end else begin
          wd_next = wd_reg + 1'b1;
        end
      end

      DONE: begin
        // Requesters drop their req during this cycle, so none is sampled.
        state_next = IDLE;
      end

      default: state_next = IDLE;
    endcase
  end

  assign bus.mem_cen   = cen_reg;
  assign bus.mem_wr    = wr_reg;
  assign bus.mem_addr  = addr_reg;
  assign bus.mem_wdata = wdata_reg;
  assign i_done        = i_done_reg;
  assign d_done        = d_done_reg;
  assign err           = err_reg;
  assign i_rdata       = i_rdata_reg;
  assign d_rdata       = d_rdata_reg;

endmodule

// File: tb/tb_fairy_mem_arbiter.sv
// Directed bench for fairy_mem_arbiter. The main instance (TIMEOUT=32) is
// served by a scripted memory; a second instance (TIMEOUT=8) has its own
// port and mostly silent memory for the watchdog scenarios.
module tb_fairy_mem_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        i_req, d_req, d_wr;
  logic [31:0] i_addr, d_addr, d_wdata;
  logic [3:0]  d_cen;
  logic        i_done, d_done, err;
  logic [31:0] i_rdata, d_rdata;

  logic        t_i_req, t_d_req, t_d_wr;
  logic [31:0] t_i_addr, t_d_addr, t_d_wdata;
  logic [3:0]  t_d_cen;
  logic        t_i_done, t_d_done, t_err;
  logic [31:0] t_i_rdata, t_d_rdata;

  fairy_mem_arbiter_if bus ();
  fairy_mem_arbiter_if bus_to ();

  fairy_mem_arbiter #(.TIMEOUT(32), .TO_W(8), .ERR_DATA(32'hDEAD_BEEF)) u_dut (
    .aclk(clk), .areset_n(rst_n),
    .i_req(i_req), .i_addr(i_addr), .i_done(i_done), .i_rdata(i_rdata),
    .d_req(d_req), .d_wr(d_wr), .d_cen(d_cen), .d_addr(d_addr),
    .d_wdata(d_wdata), .d_done(d_done), .d_rdata(d_rdata), .err(err),
    .bus(bus.master)
  );

  fairy_mem_arbiter #(.TIMEOUT(8), .TO_W(8), .ERR_DATA(32'hDEAD_BEEF)) u_dut_to (
    .aclk(clk), .areset_n(rst_n),
    .i_req(t_i_req), .i_addr(t_i_addr), .i_done(t_i_done), .i_rdata(t_i_rdata),
    .d_req(t_d_req), .d_wr(t_d_wr), .d_cen(t_d_cen), .d_addr(t_d_addr),
    .d_wdata(t_d_wdata), .d_done(t_d_done), .d_rdata(t_d_rdata), .err(t_err),
    .bus(bus_to.master)
  );

  int compared = 0;
  int mismatched = 0;

  // Results of the most recent txn() call.
  int          lat, i_cnt, d_cnt, e_cnt;
  logic        stable, wait_cen_ok, cap_wr;
  logic [3:0]  cap_cen, cen_after;
  logic [31:0] cap_addr, cap_wdata;

  // Plays the memory for one transaction on the main port. Call at #1 after
  // a posedge with the request already driven; n counts edges from the one
  // that samples the request. ack_dly < 0 means never acknowledge.
  task automatic txn(input int ack_dly, input int rrdy_dly, input logic [31:0] rd_data,
                     input logic scramble, input logic rrdy_with_ack);
    int req_cyc = 0;
    int rd_cyc = 0;
    logic acked = 1'b0;
    logic want_rd = 1'b0;
    lat = 0; i_cnt = 0; d_cnt = 0; e_cnt = 0;
    stable = 1'b1; wait_cen_ok = 1'b1; cen_after = 4'h0;
    for (int n = 1; n <= 200; n++) begin
      @(posedge clk); #1;
      bus.mem_ack = 1'b0;
      bus.mem_rrdy = 1'b0;
      if (n == 1) begin
        cap_cen = bus.mem_cen; cap_wr = bus.mem_wr;
        cap_addr = bus.mem_addr; cap_wdata = bus.mem_wdata;
      end
      if (i_done) i_cnt++;
      if (d_done) d_cnt++;
      if (err) e_cnt++;
      if (lat != 0) begin
        cen_after = bus.mem_cen;
        break;
      end
      if (i_done || d_done) begin
        lat = n;
        if (d_done) d_req = 1'b0;
        if (i_done) i_req = 1'b0;
      end else if (!acked) begin
        if (bus.mem_cen !== cap_cen || bus.mem_wr !== cap_wr ||
            bus.mem_addr !== cap_addr || bus.mem_wdata !== cap_wdata) stable = 1'b0;
        if (scramble && n == 2) begin
          d_addr = ~d_addr; d_wdata = ~d_wdata; i_addr = ~i_addr; d_cen = ~d_cen;
        end
        if (req_cyc == ack_dly) begin
          bus.mem_ack = 1'b1;
          acked = 1'b1;
          want_rd = !cap_wr;
          if (rrdy_with_ack) begin
            bus.mem_rrdy = 1'b1;
            bus.mem_rdata = ~rd_data;
          end
        end
        req_cyc++;
      end else if (want_rd) begin
        if (bus.mem_cen !== 4'hF) wait_cen_ok = 1'b0;
        if (rd_cyc == rrdy_dly) begin
          bus.mem_rrdy = 1'b1;
          bus.mem_rdata = rd_data;
        end
        rd_cyc++;
      end
    end
    $display("txn addr=%h cen=%b wr=%b lat=%0d i_done=%0d d_done=%0d err=%0d",
             cap_addr, cap_cen, cap_wr, lat, i_cnt, d_cnt, e_cnt);
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    i_req = 0; d_req = 0; d_wr = 0; d_cen = 4'h0; i_addr = 0; d_addr = 0; d_wdata = 0;
    t_i_req = 0; t_d_req = 0; t_d_wr = 0; t_d_cen = 4'h0; t_i_addr = 0; t_d_addr = 0; t_d_wdata = 0;
    bus.mem_ack = 0; bus.mem_rrdy = 0; bus.mem_rdata = 0;
    bus_to.mem_ack = 0; bus_to.mem_rrdy = 0; bus_to.mem_rdata = 0;
    repeat (2) @(posedge clk);
    #1;
    compared++; if (bus.mem_cen !== 4'hF) begin mismatched++; $display("FAIL reset_cen: got %b expected 1111", bus.mem_cen); end
    compared++; if (bus.mem_wr !== 1'b0) begin mismatched++; $display("FAIL reset_wr: got %b expected 0", bus.mem_wr); end
    compared++; if (bus.mem_addr !== 32'h0) begin mismatched++; $display("FAIL reset_addr: got %h expected 0", bus.mem_addr); end
    compared++; if (bus.mem_wdata !== 32'h0) begin mismatched++; $display("FAIL reset_wdata: got %h expected 0", bus.mem_wdata); end
    compared++; if ({i_done, d_done, err} !== 3'b000) begin mismatched++; $display("FAIL reset_pulses: got %b expected 000", {i_done, d_done, err}); end
    compared++; if (i_rdata !== 32'h0 || d_rdata !== 32'h0) begin mismatched++; $display("FAIL reset_rdata: got %h/%h expected 0/0", i_rdata, d_rdata); end
    compared++; if (bus_to.mem_cen !== 4'hF) begin mismatched++; $display("FAIL reset_cen_to: got %b expected 1111", bus_to.mem_cen); end
    rst_n = 1'b1;
  endtask

  task automatic test_single_fetch;
    i_addr = 32'h0000_0040; i_req = 1'b1;
    txn(0, 0, 32'h2402_0005, 1'b0, 1'b1);
    compared++; if (cap_addr !== 32'h40) begin mismatched++; $display("FAIL fetch_addr: got %h expected 00000040", cap_addr); end
    compared++; if (cap_cen !== 4'h0 || cap_wr !== 1'b0) begin mismatched++; $display("FAIL fetch_cen_wr: got %b/%b expected 0000/0", cap_cen, cap_wr); end
    compared++; if (lat !== 3) begin mismatched++; $display("FAIL fetch_latency: got %0d expected 3", lat); end
    compared++; if (i_cnt !== 1 || d_cnt !== 0 || e_cnt !== 0) begin mismatched++; $display("FAIL fetch_pulses: got i=%0d d=%0d e=%0d expected 1/0/0", i_cnt, d_cnt, e_cnt); end
    compared++; if (i_rdata !== 32'h2402_0005) begin mismatched++; $display("FAIL fetch_rdata: got %h expected 24020005", i_rdata); end
    compared++; if (!wait_cen_ok || cen_after !== 4'hF) begin mismatched++; $display("FAIL fetch_cen_idle: got %b/%b expected 1/1111", wait_cen_ok, cen_after); end
  endtask

  task automatic test_byte_store;
    d_wr = 1'b1; d_cen = 4'b1110; d_addr = 32'h100; d_wdata = 32'hAB; d_req = 1'b1;
    txn(2, 0, 32'h0, 1'b0, 1'b0);
    compared++; if (cap_cen !== 4'b1110 || cap_wr !== 1'b1) begin mismatched++; $display("FAIL store_cen_wr: got %b/%b expected 1110/1", cap_cen, cap_wr); end
    compared++; if (cap_addr !== 32'h100 || cap_wdata !== 32'hAB) begin mismatched++; $display("FAIL store_addr_data: got %h/%h expected 00000100/000000ab", cap_addr, cap_wdata); end
    compared++; if (!stable) begin mismatched++; $display("FAIL store_held: got unstable expected stable"); end
    compared++; if (lat !== 4) begin mismatched++; $display("FAIL store_latency: got %0d expected 4", lat); end
    compared++; if (d_cnt !== 1 || i_cnt !== 0 || e_cnt !== 0) begin mismatched++; $display("FAIL store_pulses: got d=%0d i=%0d e=%0d expected 1/0/0", d_cnt, i_cnt, e_cnt); end
    compared++; if (d_rdata !== 32'h0 || cen_after !== 4'hF) begin mismatched++; $display("FAIL store_side: got rdata=%h cen=%b expected 0/1111", d_rdata, cen_after); end
  endtask

  task automatic test_simultaneous;
    d_wr = 1'b0; d_cen = 4'h0; d_addr = 32'h200; d_req = 1'b1;
    i_addr = 32'h80; i_req = 1'b1;
    txn(0, 0, 32'h1234_5678, 1'b0, 1'b0);
    compared++; if (cap_addr !== 32'h200) begin mismatched++; $display("FAIL simul_first_addr: got %h expected 00000200", cap_addr); end
    compared++; if (d_cnt !== 1 || i_cnt !== 0 || lat !== 3) begin mismatched++; $display("FAIL simul_first_done: got d=%0d i=%0d lat=%0d expected 1/0/3", d_cnt, i_cnt, lat); end
    compared++; if (d_rdata !== 32'h1234_5678 || i_rdata !== 32'h2402_0005) begin mismatched++; $display("FAIL simul_first_rdata: got %h/%h expected 12345678/24020005", d_rdata, i_rdata); end
    compared++; if (cen_after !== 4'hF) begin mismatched++; $display("FAIL simul_gap_cen: got %b expected 1111", cen_after); end
    txn(0, 0, 32'h0C0F_FEE0, 1'b0, 1'b0);
    compared++; if (cap_addr !== 32'h80 || cap_cen !== 4'h0) begin mismatched++; $display("FAIL simul_second_req: got %h/%b expected 00000080/0000", cap_addr, cap_cen); end
    compared++; if (i_cnt !== 1 || d_cnt !== 0 || lat !== 3) begin mismatched++; $display("FAIL simul_second_done: got i=%0d d=%0d lat=%0d expected 1/0/3", i_cnt, d_cnt, lat); end
    compared++; if (i_rdata !== 32'h0C0F_FEE0 || d_rdata !== 32'h1234_5678) begin mismatched++; $display("FAIL simul_second_rdata: got %h/%h expected 0c0ffee0/12345678", i_rdata, d_rdata); end
  endtask

  task automatic test_slow_memory;
    d_wr = 1'b0; d_cen = 4'h0; d_addr = 32'h300; d_req = 1'b1;
    txn(10, 20, 32'h5A5A_A5A5, 1'b1, 1'b0);
    compared++; if (!stable || cap_addr !== 32'h300) begin mismatched++; $display("FAIL slow_stable: got stable=%b addr=%h expected 1/00000300", stable, cap_addr); end
    compared++; if (!wait_cen_ok) begin mismatched++; $display("FAIL slow_wait_cen: got cen active in read wait expected 1111"); end
    compared++; if (lat !== 33) begin mismatched++; $display("FAIL slow_latency: got %0d expected 33", lat); end
    compared++; if (d_cnt !== 1 || e_cnt !== 0 || i_cnt !== 0) begin mismatched++; $display("FAIL slow_pulses: got d=%0d e=%0d i=%0d expected 1/0/0", d_cnt, e_cnt, i_cnt); end
    compared++; if (d_rdata !== 32'h5A5A_A5A5) begin mismatched++; $display("FAIL slow_rdata: got %h expected 5a5aa5a5", d_rdata); end
  endtask

  task automatic test_timeout;
    int done_at = 0;
    int pulses = 0;
    logic err_at = 1'b0;
    // Load with no ack ever: watchdog fires after 8 request cycles.
    t_d_wr = 1'b0; t_d_cen = 4'h0; t_d_addr = 32'h400; t_d_req = 1'b1;
    for (int n = 1; n <= 20; n++) begin
      @(posedge clk); #1;
      if (t_d_done) begin
        pulses++;
        if (done_at == 0) begin done_at = n; err_at = t_err; t_d_req = 1'b0; end
      end
      if (done_at != 0 && n >= done_at + 2) break;
    end
    $display("txn addr=00000400 timeout load done_at=%0d err=%b", done_at, err_at);
    compared++; if (done_at !== 9 || err_at !== 1'b1) begin mismatched++; $display("FAIL timeout_load: got done_at=%0d err=%b expected 9/1", done_at, err_at); end
    compared++; if (pulses !== 1 || t_d_rdata !== 32'hDEAD_BEEF) begin mismatched++; $display("FAIL timeout_load_data: got pulses=%0d rdata=%h expected 1/deadbeef", pulses, t_d_rdata); end
    // Next request is served normally (acked store).
    done_at = 0; err_at = 1'b0;
    t_d_wr = 1'b1; t_d_wdata = 32'h77; t_d_addr = 32'h404; t_d_req = 1'b1;
    for (int n = 1; n <= 20; n++) begin
      @(posedge clk); #1;
      bus_to.mem_ack = (n == 1);
      if (t_d_done && done_at == 0) begin done_at = n; err_at = t_err; t_d_req = 1'b0; end
      if (done_at != 0) break;
    end
    bus_to.mem_ack = 1'b0;
    $display("txn addr=00000404 store after timeout done_at=%0d err=%b", done_at, err_at);
    compared++; if (done_at !== 2 || err_at !== 1'b0) begin mismatched++; $display("FAIL timeout_recover: got done_at=%0d err=%b expected 2/0", done_at, err_at); end
    // Fetch acked but read data never arrives.
    done_at = 0; err_at = 1'b0;
    @(posedge clk); #1;
    t_i_addr = 32'h500; t_i_req = 1'b1;
    for (int n = 1; n <= 20; n++) begin
      @(posedge clk); #1;
      bus_to.mem_ack = (n == 1);
      if (t_i_done && done_at == 0) begin done_at = n; err_at = t_err; t_i_req = 1'b0; end
      if (done_at != 0) break;
    end
    bus_to.mem_ack = 1'b0;
    $display("txn addr=00000500 fetch read timeout done_at=%0d err=%b", done_at, err_at);
    compared++; if (done_at !== 10 || err_at !== 1'b1 || t_i_rdata !== 32'hDEAD_BEEF) begin mismatched++; $display("FAIL timeout_fetch: got done_at=%0d err=%b rdata=%h expected 10/1/deadbeef", done_at, err_at, t_i_rdata); end
  endtask

  task automatic test_reset_mid_read;
    int pulses = 0;
    i_addr = 32'h600; i_req = 1'b1;
    @(posedge clk); #1;
    bus.mem_ack = 1'b1;
    @(posedge clk); #1;
    bus.mem_ack = 1'b0;
    #2 rst_n = 1'b0;
    i_req = 1'b0;
    #1;
    compared++; if (bus.mem_addr !== 32'h0 || bus.mem_cen !== 4'hF) begin mismatched++; $display("FAIL reset_async: got addr=%h cen=%b expected 0/1111", bus.mem_addr, bus.mem_cen); end
    repeat (2) begin
      @(posedge clk); #1;
      if (i_done || d_done) pulses++;
    end
    compared++; if (pulses !== 0) begin mismatched++; $display("FAIL reset_no_done: got %0d pulses expected 0", pulses); end
    rst_n = 1'b1;
    i_addr = 32'h640; i_req = 1'b1;
    txn(0, 0, 32'h1111_2222, 1'b0, 1'b0);
    compared++; if (cap_addr !== 32'h640 || lat !== 3 || i_cnt !== 1) begin mismatched++; $display("FAIL reset_fresh_fetch: got addr=%h lat=%0d i=%0d expected 00000640/3/1", cap_addr, lat, i_cnt); end
    compared++; if (i_rdata !== 32'h1111_2222) begin mismatched++; $display("FAIL reset_fresh_rdata: got %h expected 11112222", i_rdata); end
  endtask

  initial begin
    test_reset();
    test_single_fetch();
    test_byte_store();
    test_simultaneous();
    test_slow_memory();
    test_timeout();
    test_reset_mid_read();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/fairy_mem_arbiter.md
Name: fairy_mem_arbiter

Overview:
Sits directly downstream of the CPU core's separate instruction and data SRAM ports and merges them onto one unified, handshaked memory port. Owns the ack/rrdy protocol the core does not track today. Grants one transaction at a time, data over instruction, with a per-transaction watchdog. Returns read data and completion pulses to each requester.

Parameters:
TIMEOUT, 255, cycles a granted transaction may wait for mem_ack or mem_rrdy before forced error completion
TO_W, 8, width of watchdog counter (must hold TIMEOUT)
ERR_DATA, 32'h0000_0000, rdata returned on a timed-out read

Ports:
aclk  in  1  clock, all state on rising edge
areset_n  in  1  asynchronous active-low reset
i_req  in  1  instruction fetch request, held until i_done
i_addr  in  32  fetch word address
i_done  out  1  one-cycle pulse: fetch complete, i_rdata valid
i_rdata  out  32  fetch data, registered
d_req  in  1  data request, held until d_done
d_wr  in  1  1=store, 0=load
d_cen  in  4  active-low byte enables (4'b0000 = full word)
d_addr  in  32  data word address
d_wdata  in  32  store data
d_done  out  1  one-cycle pulse: load/store complete
d_rdata  out  32  load data, registered
err  out  1  one-cycle pulse with i_done/d_done when completion was a timeout
mem_cen  out  4  active-low byte enables; 4'b1111 = no request
mem_wr  out  1  write strobe
mem_addr  out  32  address
mem_wdata  out  32  write data
mem_ack  in  1  memory accepted the request this cycle
mem_rrdy  in  1  read data valid this cycle
mem_rdata  in  32  read data

Behaviour:
- Reset (async, areset_n=0): state IDLE, owner=inst, watchdog=0, mem_cen=4'b1111, mem_wr=0, mem_addr=0, mem_wdata=0, i_done=d_done=err=0, i_rdata=d_rdata=0. Reset mid-transaction abandons it; no done pulse issued.
- States: IDLE, REQ, WAIT_RD, DONE. All outputs registered.
- IDLE: if d_req -> latch d_* into mem_* regs, owner=data, REQ. Else if i_req -> mem_cen=4'b0000, mem_wr=0, mem_addr=i_addr, owner=inst, REQ. Both high same cycle: data wins; inst waits.
- REQ: mem_* held stable. On mem_ack: store -> DONE; load/fetch -> mem_cen=4'b1111, mem_wr=0, WAIT_RD. A mem_rrdy coincident with mem_ack is ignored (rrdy counts only in WAIT_RD).
- WAIT_RD: on mem_rrdy capture mem_rdata into owner's rdata reg -> DONE.
- DONE: exactly one cycle; owner's done pulses high; mem_cen=4'b1111; req inputs ignored this cycle (requester drops req here); -> IDLE.
- Minimum latency, req sampled at edge T, ack/rrdy each same-cycle: REQ T+1, WAIT_RD T+2, DONE T+3 (done high in cycle T+3). Store: done at T+2. Next grant sampled at T+4 earliest.
- Watchdog: cleared on entering REQ and WAIT_RD, increments each cycle there; on reaching TIMEOUT with no ack/rrdy -> DONE with err=1; load/fetch rdata=ERR_DATA; mem_cen=4'b1111.
- Inputs are sampled only in IDLE; changes to d_*/i_* while granted do not affect mem_*.
- Non-owner rdata regs unchanged by other owner's traffic.

Test Plan:
- Single fetch: i_req, i_addr=32'h0000_0040, mem_ack and mem_rrdy one cycle later each, mem_rdata=32'h2402_0005 -> mem_addr=32'h40, mem_cen=0000, i_done pulse with i_rdata=32'h2402_0005, 4 cycles req-to-done, d_done never high.
- Byte store: d_req, d_wr=1, d_cen=4'b1110, d_addr=32'h100, d_wdata=32'hAB -> mem_cen=1110, mem_wr=1 held until ack; d_done one cycle after ack; no WAIT_RD.
- Simultaneous i_req and d_req (load, 32'h200 -> 32'h1234_5678) -> data served first, d_rdata=32'h1234_5678; fetch issued only after DONE; both complete, mem_cen=1111 between.
- Slow memory: ack delayed 10 cycles, rrdy 20 more -> mem_* stable throughout, single done pulse, err=0.
- Timeout: TIMEOUT=8, mem_ack never -> err and d_done pulse together 9 cycles after grant, d_rdata=ERR_DATA, arbiter returns to IDLE and serves next request.
- Reset in WAIT_RD -> mem_cen=1111 immediately (async), no done pulse, fresh fetch afterward completes normally.
